stack_unit: RTL
===============

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have port: clk  in  1  rising-edge clock.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: cmd_valid  in  1  push/pop request from the decode-stage controller.
REQ-004 SHALL have port: cmd_ready  out  1  unit can accept a command this cycle.
REQ-005 SHALL have port: cmd_pop  in  1  0 = push, 1 = pop.
REQ-006 SHALL have port: cmd_sel  in  2  payload select: 00 flags, 01 PC, 11 register, 10 reserved.
REQ-007 SHALL have port: push_data  in  16  register payload.
REQ-008 SHALL have port: push_pc  in  32  PC payload.
REQ-009 SHALL have port: push_flags  in  3  flags payload.
REQ-010 SHALL have port: mem_req  out  1  data-memory access strobe.
REQ-011 SHALL have port: mem_we  out  1  1 = write, 0 = read; meaningful only when mem_req=1.
REQ-012 SHALL have port: mem_addr  out  12  word address.
REQ-013 SHALL have port: mem_wdata  out  16  write data.
REQ-014 SHALL have port: mem_rdata  in  16  read data, valid exactly 1 cycle after a read mem_req.
REQ-015 SHALL have port: pop_valid  out  1  1-cycle pulse; pop result present.
REQ-016 SHALL have port: pop_sel  out  2  cmd_sel of the completed pop.
REQ-017 SHALL have port: pop_data  out  32  popped value: PC full width, register/flags zero-extended.
REQ-018 SHALL have port: sp  out  12  current stack pointer, addressing the next free word.
REQ-019 SHALL have port: err  out  1  1-cycle pulse; command rejected.

Function
REQ-020 SHALL implement these states: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_WAIT, DONE.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; a command is accepted at cycle T when cmd_valid and cmd_ready are both 1 at the T edge.
REQ-022 SHALL grow the stack downward.
  - Push: write mem[sp], then sp-1.
  - Pop: sp+1, then read mem[sp].
  - All sp arithmetic is 12-bit.
REQ-023 SHALL handle a register or flags push as follows.
  - Accept T -> PUSH_LO, which issues the write at T+1.
  - Write: mem_req=1, mem_we=1, mem_addr=sp, mem_wdata=push_data or {13'b0, push_flags}.
  - sp decrements at the T+1 edge; return to IDLE, cmd_ready=1 at T+2.
REQ-024 SHALL handle a PC push as follows.
  - PUSH_HI at T+1 writes push_pc[31:16] to sp.
  - PUSH_LO at T+2 writes push_pc[15:0] to sp-1.
  - sp decrements once per written word (net -2); IDLE at T+3.
REQ-025 SHALL capture the payload (push_data, push_flags or push_pc) in an internal register at acceptance.
REQ-026 SHALL handle a register or flags pop as follows.
  - POP_LO at T+1 issues a read at sp+1 (mem_req=1, mem_we=0) and increments sp.
  - POP_WAIT at T+2 captures mem_rdata.
  - DONE at T+3 drives pop_valid=1; IDLE at T+4.
  - pop_data = {16'b0, word} for register; {29'b0, word[2:0]} for flags.
REQ-027 SHALL handle a PC pop as follows.
  - POP_LO at T+1 reads sp+1; POP_HI at T+2 reads sp+2 and captures the low word.
  - POP_WAIT at T+3 captures the high word.
  - DONE at T+4 drives pop_valid=1, pop_data={hi, lo}; net sp +2.
REQ-028 SHALL hold pop_data and pop_sel stable from DONE until the next pop completes.
REQ-029 SHALL define stack full as sp==0x000 and empty as sp==0xFFF; address 0x000 is never written.
REQ-030 SHALL reject the following commands with no memory access and no sp change, raising err at T+1 and staying in IDLE:
  - push when sp==0x000;
  - PC push when sp<0x002;
  - pop when sp==0xFFF;
  - PC pop when sp>0xFFD;
  - cmd_sel==10.
REQ-031 SHALL make PC push and PC pop atomic: either both words transfer or neither does.
REQ-032 SHALL drive mem_req=0 in IDLE, DONE and POP_WAIT, and mem_we=0 whenever mem_req=0.
REQ-033 SHALL ignore cmd_valid and all payload inputs outside IDLE.

Reset
REQ-034 SHALL, while reset=0, force: state IDLE, sp=0xFFF, cmd_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, pop_valid=0, pop_sel=0, pop_data=0, err=0.
REQ-035 SHALL drive cmd_ready=1 on the first clock edge after reset deasserts.
REQ-036 SHALL, when reset asserts mid-sequence, abort the operation immediately with no further memory access; a partial PC push leaves memory partially written, but sp=0xFFF.

Verification
REQ-037 SHALL test register push then pop.
  - Stimulus: push reg 0xBEEF, then pop reg.
  - Response: write at 0xFFF; sp 0xFFE then 0xFFF; pop_valid at T+3 with pop_data=0x0000BEEF, pop_sel=11.
REQ-038 SHALL test PC push then pop.
  - Stimulus: push PC 0x1234ABCD, then pop PC.
  - Response: writes 0xFFF<-0x1234, 0xFFE<-0xABCD; pop reads 0xFFE then 0xFFF; pop_data=0x1234ABCD; sp back to 0xFFF.
REQ-039 SHALL test flags round-trip.
  - Stimulus: push flags 3'b101, then pop flags.
  - Response: mem_wdata=0x0005; pop_data=0x00000005.
REQ-040 SHALL test underflow.
  - Stimulus: pop reg from reset state.
  - Response: err pulse at T+1, no mem_req, sp=0xFFF, cmd_ready=1 at T+1.
REQ-041 SHALL test full-stack boundaries.
  - Stimulus: preload sp=0x001 via 4094 register pushes.
  - Response: PC push rejected with err; a register push writes 0x001 and gives sp=0x000; a further push is rejected with err.
REQ-042 SHALL test reset mid-operation.
  - Stimulus: assert reset during PUSH_LO of a PC push.
  - Response: mem_req=0 at once; sp=0xFFF; pop_valid=0; after release, cmd_ready=1.

Source files
------------

// File: rtl/stack_unit_if.sv
// Command, memory and result signals of the hardware stack unit.
// The unit takes the slave side; the decode controller and data memory take the master side.
interface stack_unit_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_pop;
   logic [1:0]  cmd_sel;
   logic [15:0] push_data;
   logic [31:0] push_pc;
   logic [2:0]  push_flags;
   logic        mem_req;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        pop_valid;
   logic [1:0]  pop_sel;
   logic [31:0] pop_data;
   logic [11:0] sp;
   logic        err;

   modport slave (
      input  cmd_valid, cmd_pop, cmd_sel, push_data, push_pc, push_flags, mem_rdata,
      output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, pop_valid, pop_sel, pop_data, sp, err
   );

   modport master (
      output cmd_valid, cmd_pop, cmd_sel, push_data, push_pc, push_flags, mem_rdata,
      input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata, pop_valid, pop_sel, pop_data, sp, err
   );
endinterface

// File: rtl/stack_unit.sv
// Downward-growing hardware stack in data memory: 16-bit register/flags words and
// two-word PC frames (high word at the higher address), with bounds rejection.
module stack_unit (
   input logic        clk,
   input logic        reset,
   stack_unit_if.slave bus
);
   localparam logic [1:0] SEL_FLAGS = 2'b00;
   localparam logic [1:0] SEL_PC    = 2'b01;
   localparam logic [1:0] SEL_REG   = 2'b11;
   localparam logic [1:0] SEL_RSV   = 2'b10;

   typedef enum logic [2:0] {IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, POP_WAIT, DONE} state_t;

   state_t      state_q, state_d;
   logic [11:0] sp_q, sp_d;
   logic [1:0]  sel_q, sel_d;
   logic [31:0] pl_q, pl_d;
   logic [15:0] lo_q, lo_d;
   logic        cmd_ready_q, cmd_ready_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [11:0] mem_addr_q, mem_addr_d;
   logic [15:0] mem_wdata_q, mem_wdata_d;
   logic        pop_valid_q, pop_valid_d;
   logic [1:0]  pop_sel_q, pop_sel_d;
   logic [31:0] pop_data_q, pop_data_d;
   logic        err_q, err_d;

   logic is_pc, reject;

   // A PC frame needs room for both words up front, which keeps it atomic.
   always_comb begin
      is_pc  = (bus.cmd_sel == SEL_PC);
      reject = (bus.cmd_sel == SEL_RSV) ||
               (!bus.cmd_pop && (is_pc ? (sp_q < 12'd2)     : (sp_q == 12'h000))) ||
               ( bus.cmd_pop && (is_pc ? (sp_q > 12'hFFD)   : (sp_q == 12'hFFF)));
   end

   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      sel_d       = sel_q;
      pl_d        = pl_q;
      lo_d        = lo_q;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      pop_valid_d = 1'b0;
      pop_sel_d   = pop_sel_q;
      pop_data_d  = pop_data_q;
      err_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               if (reject) begin
                  err_d = 1'b1;
               end else if (!bus.cmd_pop) begin
                  sel_d       = bus.cmd_sel;
                  pl_d        = is_pc ? bus.push_pc :
                                (bus.cmd_sel == SEL_REG) ? {16'b0, bus.push_data} : {29'b0, bus.push_flags};
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = sp_q;
                  mem_wdata_d = is_pc ? bus.push_pc[31:16] : pl_d[15:0];
                  state_d     = is_pc ? PUSH_HI : PUSH_LO;
               end else begin
                  sel_d      = bus.cmd_sel;
                  mem_req_d  = 1'b1;
                  mem_addr_d = sp_q + 12'd1;
                  state_d    = POP_LO;
               end
            end
         end
         PUSH_HI: begin
            sp_d        = sp_q - 12'd1;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = sp_q - 12'd1;
            mem_wdata_d = pl_q[15:0];
            state_d     = PUSH_LO;
         end
         PUSH_LO: begin
            sp_d    = sp_q - 12'd1;
            state_d = IDLE;
         end
         POP_LO: begin
            sp_d = sp_q + 12'd1;
            if (sel_q == SEL_PC) begin
               mem_req_d  = 1'b1;
               mem_addr_d = sp_q + 12'd2;
               state_d    = POP_HI;
            end else begin
               state_d = POP_WAIT;
            end
         end
         POP_HI: begin
            sp_d    = sp_q + 12'd1;
            lo_d    = bus.mem_rdata;
            state_d = POP_WAIT;
         end
         POP_WAIT: begin
            pop_valid_d = 1'b1;
            pop_sel_d   = sel_q;
            case (sel_q)
               SEL_PC:    pop_data_d = {bus.mem_rdata, lo_q};
               SEL_FLAGS: pop_data_d = {29'b0, bus.mem_rdata[2:0]};
               default:   pop_data_d = {16'b0, bus.mem_rdata};
            endcase
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         sp_q        <= 12'hFFF;
         sel_q       <= 2'b00;
         pl_q        <= 32'b0;
         lo_q        <= 16'b0;
         cmd_ready_q <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 12'b0;
         mem_wdata_q <= 16'b0;
         pop_valid_q <= 1'b0;
         pop_sel_q   <= 2'b00;
         pop_data_q  <= 32'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         sel_q       <= sel_d;
         pl_q        <= pl_d;
         lo_q        <= lo_d;
         cmd_ready_q <= cmd_ready_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         pop_valid_q <= pop_valid_d;
         pop_sel_q   <= pop_sel_d;
         pop_data_q  <= pop_data_d;
         err_q       <= err_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.pop_valid = pop_valid_q;
   assign bus.pop_sel   = pop_sel_q;
   assign bus.pop_data  = pop_data_q;
   assign bus.sp        = sp_q;
   assign bus.err       = err_q;
endmodule
